// File: rtl/ccff_loader.sv
// Configuration-chain loader: shifts a preamble plus a CHAIN_LEN-bit payload into
// ccff_head on prog_clk and checks that the preamble reappears intact at ccff_tail.
module ccff_loader #(
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned PRE_LEN   = 8,
    parameter logic [31:0] PREAMBLE  = 32'h000000A5
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              Test_en,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              err
);

    localparam int unsigned TOTAL     = CHAIN_LEN + PRE_LEN;
    localparam int unsigned CNT_W     = $clog2(TOTAL + 1);
    localparam int unsigned N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int unsigned LAST_BITS = ((CHAIN_LEN % WORD_W) == 0) ? WORD_W : (CHAIN_LEN % WORD_W);
    localparam int unsigned WC_W      = $clog2(N_WORDS + 1);
    localparam int unsigned BC_W      = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_PAY, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]  shift_idx_q, shift_idx_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [BC_W-1:0]   buf_bits_q, buf_bits_d;
    logic [WC_W-1:0]   words_left_q, words_left_d;
    logic              mis_q, mis_d;
    logic              bs_ready_q, bs_ready_d;
    logic              head_q, head_d;
    logic              shift_en_q, shift_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              err_q, err_d;

    logic              issue_c;
    logic              issue_bit_c;
    logic              take_c;
    logic [4:0]        pre_idx_c;
    logic [4:0]        tail_idx_c;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q      <= ST_IDLE;
            pre_cnt_q    <= '0;
            shift_idx_q  <= '0;
            buf_q        <= '0;
            buf_bits_q   <= '0;
            words_left_q <= '0;
            mis_q        <= 1'b0;
            bs_ready_q   <= 1'b0;
            head_q       <= 1'b0;
            shift_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            shift_idx_q  <= shift_idx_d;
            buf_q        <= buf_d;
            buf_bits_q   <= buf_bits_d;
            words_left_q <= words_left_d;
            mis_q        <= mis_d;
            bs_ready_q   <= bs_ready_d;
            head_q       <= head_d;
            shift_en_q   <= shift_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        shift_idx_d  = shift_idx_q;
        buf_d        = buf_q;
        buf_bits_d   = buf_bits_q;
        words_left_d = words_left_q;
        mis_d        = mis_q;
        issue_c      = 1'b0;
        issue_bit_c  = 1'b0;
        take_c       = 1'b0;
        pre_idx_c    = 5'(CNT_W'(PRE_LEN - 1) - pre_cnt_q);
        tail_idx_c   = 5'(CNT_W'(TOTAL - 1) - shift_idx_q);

        // The chain moves one flop per active shift cycle; the preamble reaches the tail
        // during the last PRE_LEN of them.
        if (shift_en_q) begin
            shift_idx_d = shift_idx_q + CNT_W'(1);
            if ((shift_idx_q >= CNT_W'(CHAIN_LEN)) && (ccff_tail != PREAMBLE[tail_idx_c])) begin
                mis_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !Test_en) begin
                    state_d      = ST_PRE;
                    pre_cnt_d    = '0;
                    shift_idx_d  = '0;
                    mis_d        = 1'b0;
                    buf_bits_d   = '0;
                    words_left_d = WC_W'(N_WORDS);
                end
            end
            ST_PRE: begin
                issue_c     = 1'b1;
                issue_bit_c = PREAMBLE[pre_idx_c];
                pre_cnt_d   = pre_cnt_q + CNT_W'(1);
                take_c      = bs_ready_q && bs_valid;
                if (pre_cnt_q == CNT_W'(PRE_LEN - 1)) begin
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                if (buf_bits_q != '0) begin
                    issue_c     = 1'b1;
                    issue_bit_c = buf_q[WORD_W-1];
                    buf_d       = buf_q << 1;
                    buf_bits_d  = buf_bits_q - BC_W'(1);
                end
                take_c = bs_ready_q && bs_valid;
                if (shift_en_q && (shift_idx_q == CNT_W'(TOTAL - 1))) begin
                    state_d = ST_DONE;
                end
            end
        endcase

        // Final word keeps only its upper LAST_BITS bits.
        if (take_c) begin
            buf_d        = bs_data;
            buf_bits_d   = (words_left_q == WC_W'(1)) ? BC_W'(LAST_BITS) : BC_W'(WORD_W);
            words_left_d = words_left_q - WC_W'(1);
        end

        if (abort) begin
            state_d      = ST_IDLE;
            issue_c      = 1'b0;
            buf_bits_d   = '0;
            words_left_d = '0;
            mis_d        = 1'b0;
        end

        shift_en_d = issue_c;
        head_d     = issue_c ? issue_bit_c : head_q;
        busy_d     = (state_d == ST_PRE) || (state_d == ST_PAY);
        done_d     = (state_d == ST_DONE);
        pass_d     = done_d && !mis_d;
        err_d      = done_d && mis_d;
        // Ready when the buffer will be empty or draining its last bit, and at the last preamble bit.
        bs_ready_d = ((state_d == ST_PAY) && (words_left_d != '0) && (buf_bits_d <= BC_W'(1)))
                  || ((state_d == ST_PRE) && (pre_cnt_d == CNT_W'(PRE_LEN - 1)));
    end

    assign bs_ready      = bs_ready_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err           = err_q;

endmodule
